blink_arb: RTL

Round-robin scheduler that shares a single blink LED between `NREQ` requesters. Each requester asks for a burst of N blinks. The arbiter grants one requester at a time and sequences the LED on/off phases from a shared free-running prescaler counter. When the burst completes, the arbiter signals completion to that requester. It sits between the status/event sources and the board LED pin, in place of a bare blinker.

---
 rtl/blink_arb.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/blink_arb.sv
// blink_arb: shares one blink LED between NREQ requesters. Each granted
// requester gets a burst of nblink blinks (ON/OFF phases of 2^CBITS cycles
// each), followed by one dark GAP phase and a one-cycle FIN that pulses done.
// Phases are timed from a shared free-running prescaler.
//
// Build option: define BLINK_ARB_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer). Otherwise arbitration is round-robin.
module blink_arb #(
   parameter int NREQ  = 4,
   parameter int CBITS = 14,
   parameter int NBITS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*NBITS-1:0]  nblink,
   output logic [NREQ-1:0]        grant,
   output logic                   led,
   output logic                   busy,
   output logic                   done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_ON,
      S_OFF,
      S_GAP,
      S_FIN
   } state_t;

   state_t             state_q, state_d;
   logic [CBITS-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0]    grant_q, grant_d;
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [NBITS-1:0]   left_q, left_d;
   logic               led_q, led_d;
   logic               done_q, done_d;

   logic               tick;
   logic               abort;
   logic               release_g;
   logic               found;
   logic [IW-1:0]      win_idx;
   logic [IW-1:0]      scan;
   logic [IW-1:0]      start_idx;

   // Prescaler free-runs in every state; tick marks the last cycle of a phase.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      tick  = &cnt_q;
   end

`ifdef BLINK_ARB_PRIO_EN
   assign start_idx = '0;
`else
   logic [IW-1:0] ptr_q, ptr_d;

   // Pointer moves to the requester after the one just released.
   always_comb begin
      ptr_d = ptr_q;
      if (release_g) begin
         ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign start_idx = ptr_q;
`endif

   // Winner search: first requester at or after start_idx, wrapping.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      scan    = '0;
      for (int off = 0; off < NREQ; off++) begin
         scan = IW'((int'(start_idx) + off) % NREQ);
         if (!found && req[scan]) begin
            found   = 1'b1;
            win_idx = scan;
         end
      end
   end

   // Next-state and output decode for the burst sequencer.
   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      left_d    = left_q;
      done_d    = 1'b0;
      release_g = 1'b0;
      abort     = tick && !req[gidx_q];

      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d = NREQ'(1) << win_idx;
               gidx_d  = win_idx;
               left_d  = nblink[int'(win_idx)*NBITS +: NBITS];
               state_d = S_SYNC;
            end
         end
         S_SYNC: begin
            if (left_q == '0) begin
               state_d = S_FIN;
               done_d  = 1'b1;
            end else if (abort) begin
               state_d = S_IDLE;
            end else if (tick) begin
               state_d = S_ON;
            end
         end
         S_ON: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (tick) begin
               // ON is only entered with left_q != 0, so this cannot underflow.
               left_d  = left_q - 1'b1;
               state_d = S_OFF;
            end
         end
         S_OFF: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (tick) begin
               state_d = (left_q != '0) ? S_ON : S_GAP;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (tick) begin
               state_d = S_FIN;
               done_d  = 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Leaving a burst (normal finish or abort) drops the grant.
      if (state_q != S_IDLE && state_q != S_FIN &&
          (state_d == S_FIN || state_d == S_IDLE)) begin
         grant_d   = '0;
         release_g = 1'b1;
      end

      led_d = (state_d == S_ON);
   end

   // State and output registers.
   // NOTE: sequential blocks use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         gidx_q  <= '0;
         left_q  <= '0;
         led_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         left_q  <= left_d;
         led_q   <= led_d;
         done_q  <= done_d;
      end
   end

   assign grant = grant_q;
   assign led   = led_q;
   assign done  = done_q;
   assign busy  = |grant_q;

endmodule
